// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: framing FSM encoding and frame geometry.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Accumulator width for the fractional baud generator: enough integer bits
    // to cover the clock/baud ratio plus 8 fraction bits for accuracy.
    function automatic int baud_acc_width(input int clk_freq, input int rate);
        return $clog2(clk_freq / rate) + 8;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_baud.sv
// BaudTickGen: fractional accumulator producing one-cycle ticks at Baud*Oversampling.
// While enable is low the accumulator sits preset, so the first tick after enable
// arrives one full tick period later.
module uart_tx_arbiter_baud
    import uart_tx_arbiter_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 9600,
    parameter int Oversampling = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int AccWidth = baud_acc_width(ClkFrequency, Baud * Oversampling);
    localparam longint IncL =
        ((longint'(Baud) * longint'(Oversampling) << AccWidth) + longint'(ClkFrequency / 2))
        / longint'(ClkFrequency);
    localparam logic [AccWidth:0] Inc = (AccWidth + 1)'(IncL);

    logic [AccWidth:0] acc_reg;

    // Accumulate while enabled (carry dropped each step); otherwise hold the preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= Inc;
        end else if (enable) begin
            acc_reg <= {1'b0, acc_reg[AccWidth-1:0]} + Inc;
        end else begin
            acc_reg <= Inc;
        end
    end

    assign tick = acc_reg[AccWidth];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ byte producers.
// One byte is accepted per frame (start, 8 data LSB first, STOP_BITS stop bits).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int NUM_REQ   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [8*NUM_REQ-1:0]           req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int IdW = $clog2(NUM_REQ);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    state_t                      state_reg;
    logic [UART_DATA_BITS-1:0]   data_reg;
    logic [2:0]                  bit_idx_reg;
    logic                        stop_cnt_reg;
    logic                        baud_en_reg;
    logic [IdW-1:0]              last_reg;
    logic                        tx_reg;
    logic                        busy_reg;
    logic [IdW-1:0]              grant_reg;

    logic                        tick;
    logic                        win_found;
    logic [IdW-1:0]              win_idx;
    logic                        accept;

    uart_tx_arbiter_baud #(
        .ClkFrequency (CLK_FREQ),
        .Baud         (BAUD),
        .Oversampling (1)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (baud_en_reg),
        .tick   (tick)
    );

    // Rotating priority search: start just after the last grant, wrap to 0.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IdW'(idx);
            end
        end
    end

    // Ready is offered only in IDLE and never while reset is held.
    assign req_ready = (rst_n && (state_reg == ST_IDLE) && win_found)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx)
                       : '0;
    assign accept = |req_ready;

    // Framing FSM with registered line, busy and grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            data_reg     <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            baud_en_reg  <= 1'b0;
            last_reg     <= IdW'(NUM_REQ - 1);
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            grant_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        data_reg    <= req_data[8*win_idx +: 8];
                        grant_reg   <= win_idx;
                        last_reg    <= win_idx;
                        busy_reg    <= 1'b1;
                        tx_reg      <= 1'b0;
                        baud_en_reg <= 1'b1;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_reg      <= data_reg[0];
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_reg == LAST_BIT) begin
                            tx_reg       <= 1'b1;
                            stop_cnt_reg <= 1'b0;
                            state_reg    <= ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= data_reg[bit_idx_reg + 3'd1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            busy_reg    <= 1'b0;
                            baud_en_reg <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (1 and 2 stop bits) at 10 clk/bit.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_valid2;
    logic [31:0] req_data, req_data2;
    logic [3:0]  req_ready, req_ready2;
    logic        tx, tx2, busy, busy2;
    logic [1:0]  grant_id, grant_id2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc1_idx[$];
    int acc1_cyc[$];
    int acc2_cyc[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLK_FREQ(1000000), .BAUD(100000), .NUM_REQ(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.CLK_FREQ(1000000), .BAUD(100000), .NUM_REQ(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .tx(tx2), .busy(busy2), .grant_id(grant_id2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Log every transfer (valid & ready) seen before the accepting edge.
    always @(negedge clk) begin
        if (rst_n && |(req_valid & req_ready)) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc1_idx.push_back(i);
                    $display("accept dut1 req%0d cycle %0d", i, cyc);
                end
            end
            acc1_cyc.push_back(cyc);
        end
        if (rst_n && |(req_valid2 & req_ready2)) begin
            acc2_cyc.push_back(cyc);
            $display("accept dut2 cycle %0d", cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 2) ? tx2 : tx;
    endfunction

    // Wait for a start bit, then sample each bit at its centre (10 clk per bit).
    task automatic recv(input int which, input int nstop, input string tag, output logic [7:0] b);
        int n;
        b = '0;
        n = 0;
        while (get_tx(which) !== 1'b0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 400), 1);
        if (n >= 400) return;
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_start_bit"}, 32'(get_tx(which)), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(posedge clk);
            #1;
            b[i] = get_tx(which);
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (10) @(posedge clk);
            #1;
            check({tag, "_stop_bit"}, 32'(get_tx(which)), 1);
        end
        $display("frame %s dut%0d data=%02h", tag, which, b);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 300), 1);
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] t1_bits;
        int n;
        int base;
        int hits;

        // Reset state, with a request pending that must not see ready.
        rst_n      = 1'b0;
        req_valid  = 4'b1000;
        req_data   = 32'h0;
        req_valid2 = 4'b0000;
        req_data2  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_tx2", 32'(tx2), 1);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: single request, req0 sends 0xA5; full waveform check.
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        check("t1_ready_drop", 32'(req_ready), 0);
        check("t1_busy", 32'(busy), 1);
        check("t1_grant", 32'(grant_id), 0);
        t1_bits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? 5 : 10) @(posedge clk);
            #1;
            check($sformatf("t1_bit%0d", k), 32'(tx), 32'(t1_bits[k]));
        end
        n = 95;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_busy_len", 32'(n >= 99 && n <= 101), 1);
        $display("t1 busy length %0d clk", n);

        // Test 2: all four requesters valid continuously after a fresh reset.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        base = acc1_idx.size();
        for (int f = 0; f < 5; f++) begin
            recv(1, 1, $sformatf("t2_f%0d", f), b);
            check($sformatf("t2_data%0d", f), 32'(b), 32'((f % 4 + 1) * 17));
            check($sformatf("t2_grant%0d", f), 32'(grant_id), 32'(f % 4));
        end
        req_valid = 4'b0000;
        check("t2_accepts", 32'(acc1_idx.size() >= base + 5), 1);
        if (acc1_idx.size() >= base + 5) begin
            for (int f = 0; f < 5; f++) begin
                check($sformatf("t2_order%0d", f), 32'(acc1_idx[base + f]), 32'(f % 4));
            end
            for (int f = 1; f < 5; f++) begin
                n = acc1_cyc[base + f] - acc1_cyc[base + f - 1];
                check($sformatf("t2_gap%0d", f), 32'(n >= 100 && n <= 102), 1);
            end
        end
        wait_idle("t2");

        // Test 3: two stop bits, req2 sends 0xFF; next accept spaced ~111 clk.
        base = acc2_cyc.size();
        req_data2  = 32'h00FF_0000;
        req_valid2 = 4'b0100;
        recv(2, 2, "t3", b);
        check("t3_data", 32'(b), 32'hFF);
        check("t3_grant", 32'(grant_id2), 2);
        n = 0;
        while (acc2_cyc.size() < base + 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid2 = 4'b0000;
        check("t3_second_accept", 32'(acc2_cyc.size() >= base + 2), 1);
        if (acc2_cyc.size() >= base + 2) begin
            n = acc2_cyc[base + 1] - acc2_cyc[base];
            check("t3_spacing", 32'(n >= 109 && n <= 113), 1);
        end

        // Test 4: req1 raises then drops valid while req0 is mid-frame.
        base = acc1_idx.size();
        req_data  = 32'h0000_003E;
        req_valid = 4'b0001;
        #1;
        check("t4_ready0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (30) @(posedge clk);
        #1;
        req_valid = 4'b0010;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[1]) hits++;
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
        check("t4_ready1_hits", 32'(hits), 0);
        wait_idle("t4");
        repeat (20) @(posedge clk);
        #1;
        check("t4_accepts", 32'(acc1_idx.size()), 32'(base + 1));
        if (acc1_idx.size() > base) check("t4_idx", 32'(acc1_idx[base]), 0);

        // Test 5: reset during data bit 4, then a pending req3 is served afresh.
        req_data  = 32'h3C00_0000;
        req_valid = 4'b0001;
        #1;
        check("t5_ready0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        repeat (55) @(posedge clk);
        #1;
        check("t5_bit4_low", 32'(tx), 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", 32'(tx), 1);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(posedge clk); #1;
        check("t5_hold_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        #1;
        check("t5_ready3", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        recv(1, 1, "t5", b);
        check("t5_data", 32'(b), 32'h3C);
        check("t5_grant", 32'(grant_id), 3);
        wait_idle("t5");

        // Test 6: req_data changes right after the accept; latched byte must be sent.
        req_data  = 32'h0000_5A00;
        req_valid = 4'b0010;
        #1;
        check("t6_ready1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_C300;
        recv(1, 1, "t6", b);
        check("t6_data", 32'(b), 32'h5A);
        check("t6_grant", 32'(grant_id), 1);
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
